// File: rtl/control_contador.sv
// Sequencer for the 8-bit count register: start/stop/clear command interface,
// programmable terminal count, prescaler and one-shot / auto-reload behaviour.
module control_contador #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   q_q, q_d;
   logic [DIV_W-1:0]   presc_q, presc_d;
   logic [WIDTH-1:0]   limit_q, limit_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               reload_q, reload_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;

   logic accept, is_start, is_stop, is_clear, tick;

   always_comb begin
      accept   = cmd_valid & ready_q;
      is_start = accept & (cmd_op == OP_START);
      is_stop  = accept & (cmd_op == OP_STOP);
      is_clear = accept & (cmd_op == OP_CLEAR);
      tick     = (state_q == S_RUN) & (presc_q == div_q);

      state_d  = state_q;
      q_d      = q_q;
      presc_d  = presc_q;
      limit_d  = limit_q;
      div_d    = div_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      // Any accepted command, NOP included, costs one dead cycle on ready.
      ready_d  = ~accept;

      case (state_q)
         S_IDLE: begin
            if (is_start) begin
               limit_d  = cfg_limit;
               div_d    = cfg_div;
               reload_d = cfg_reload;
               q_d      = '0;
               presc_d  = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (is_stop) begin
               state_d = S_HOLD;
            end else begin
               presc_d = tick ? '0 : presc_q + DIV_W'(1);
               if (tick) begin
                  if (q_q != limit_q) begin
                     q_d = q_q + WIDTH'(1);
                  end else begin
                     done_d = 1'b1;
                     if (reload_q) q_d     = '0;
                     else          state_d = S_IDLE;
                  end
               end
            end
         end
         S_HOLD: begin
            if (is_start) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase

      // Clear overrides everything, including a coincident terminal tick.
      if (is_clear) begin
         q_d     = '0;
         presc_d = '0;
         state_d = S_IDLE;
         done_d  = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         q_q      <= '0;
         presc_q  <= '0;
         limit_q  <= '0;
         div_q    <= '0;
         reload_q <= 1'b0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         presc_q  <= presc_d;
         limit_q  <= limit_d;
         div_q    <= div_d;
         reload_q <= reload_d;
         done_q   <= done_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign q         = q_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = ready_q;

endmodule
